// File: rtl/e1ofn_pkg.sv
// Shared types and digit helpers for the e1ofN <-> valid/ready bridge.
// Helpers work on MAX_N-wide rails so any N up to MAX_N uses the same code.
package e1ofn_pkg;

    localparam int M_DEF = 9;
    localparam int N_DEF = 2;
    localparam int B_DEF = (N_DEF > 1) ? $clog2(N_DEF) : 1;
    localparam int W_DEF = M_DEF * B_DEF;
    localparam int MAX_N = 16;

    typedef enum logic [1:0] {DIG_NEUTRAL, DIG_VALID, DIG_MULTI} dig_class_t;
    typedef enum logic {R_IDLE, R_ACK} rx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_NEUTRAL} tx_state_t;

    function automatic dig_class_t digit_class(input logic [MAX_N-1:0] rails, input int n);
        int cnt;
        cnt = 0;
        for (int k = 0; k < MAX_N; k++)
            if (k < n && rails[k]) cnt++;
        if (cnt == 0)      return DIG_NEUTRAL;
        else if (cnt == 1) return DIG_VALID;
        else               return DIG_MULTI;
    endfunction

    // Index of the high rail; only meaningful for a valid digit.
    function automatic int decode_digit(input logic [MAX_N-1:0] rails, input int n);
        int v;
        v = 0;
        for (int k = 0; k < MAX_N; k++)
            if (k < n && rails[k]) v = v | k;
        return v;
    endfunction

    // Out-of-range values saturate onto the top rail.
    function automatic logic [MAX_N-1:0] encode_digit(input int val, input int n);
        logic [MAX_N-1:0] r;
        int sat;
        sat = (val >= n) ? n - 1 : val;
        r = '0;
        for (int k = 0; k < MAX_N; k++)
            if (k < n) r[k] = (sat == k);
        return r;
    endfunction

endpackage

// File: rtl/e1ofn_sync2.sv
// Two-flop synchronizer for asynchronous rails/handshake inputs.
module e1ofn_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/e1ofn_rtl_bridge.sv
// Bridge between QDI e1ofN_M channels and clocked valid/ready ports.
// Receive half decodes into a one-entry buffer; send half encodes onto registered rails.
module e1ofn_rtl_bridge
    import e1ofn_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int B = (N > 1) ? $clog2(N) : 1,
    parameter int W = M * B
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [M*N-1:0] rx_rails,
    output logic           rx_en,
    output logic           rx_valid,
    output logic [W-1:0]   rx_data,
    input  logic           rx_ready,
    input  logic           tx_valid,
    input  logic [W-1:0]   tx_data,
    output logic           tx_ready,
    output logic [M*N-1:0] tx_rails,
    input  logic           tx_en,
    output logic           proto_err
);

    logic [M*N-1:0] rx_s;
    logic           tx_en_s;

    e1ofn_sync2 #(.WIDTH(M*N)) u_rx_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (rx_rails),
        .q     (rx_s)
    );

    e1ofn_sync2 #(.WIDTH(1)) u_txen_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (tx_en),
        .q     (tx_en_s)
    );

    logic [M-1:0]   dig_valid, dig_neutral, dig_multi, enc_err;
    logic [W-1:0]   dec_word;
    logic [M*N-1:0] enc_word;

    for (genvar i = 0; i < M; i++) begin : g_dig
        dig_class_t cls;
        assign cls            = digit_class(MAX_N'(rx_s[i*N +: N]), N);
        assign dig_valid[i]   = (cls == DIG_VALID);
        assign dig_neutral[i] = (cls == DIG_NEUTRAL);
        assign dig_multi[i]   = (cls == DIG_MULTI);
        assign dec_word[i*B +: B] = B'(decode_digit(MAX_N'(rx_s[i*N +: N]), N));

        assign enc_word[i*N +: N] = N'(encode_digit(int'(tx_data[i*B +: B]), N));
        assign enc_err[i]         = (int'(tx_data[i*B +: B]) >= N);
    end

    logic all_valid, all_neutral, any_multi;
    assign all_valid   = &dig_valid;
    assign all_neutral = &dig_neutral;
    assign any_multi   = |dig_multi;

    // Receive FSM
    rx_state_t rx_state, rx_state_nx;
    logic      rx_capture, rx_drain;

    assign rx_drain = rx_valid && rx_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) rx_state <= R_IDLE;
        else       rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_capture  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (all_valid && !rx_valid) begin
                    rx_capture  = 1'b1;
                    rx_state_nx = R_ACK;
                end
            end
            R_ACK: begin
                // Re-enable only once the single buffer slot is free.
                if (all_neutral && (!rx_valid || rx_drain))
                    rx_state_nx = R_IDLE;
            end
            default: rx_state_nx = R_IDLE;
        endcase
    end

    assign rx_en = (rx_state == R_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (rx_capture) begin
            rx_valid <= 1'b1;
            rx_data  <= dec_word;
        end else if (rx_drain) begin
            rx_valid <= 1'b0;
        end
    end

    // Send FSM
    tx_state_t tx_state, tx_state_nx;
    logic      tx_fire, tx_clear;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) tx_state <= S_IDLE;
        else       tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_fire     = 1'b0;
        tx_clear    = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (tx_valid && tx_en_s) begin
                    tx_fire     = 1'b1;
                    tx_state_nx = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!tx_en_s) begin
                    tx_clear    = 1'b1;
                    tx_state_nx = S_NEUTRAL;
                end
            end
            S_NEUTRAL: begin
                if (tx_en_s) tx_state_nx = S_IDLE;
            end
            default: tx_state_nx = S_IDLE;
        endcase
    end

    assign tx_ready = (tx_state == S_IDLE) && tx_en_s;

    // Rails only ever move codeword -> neutral or neutral -> codeword.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         tx_rails <= '0;
        else if (tx_fire)  tx_rails <= enc_word;
        else if (tx_clear) tx_rails <= '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            proto_err <= 1'b0;
        else if (any_multi || (tx_fire && |enc_err))
            proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// Self-checking bench: directed handshakes plus randomized concurrent rx/tx traffic.
module tb_e1ofn_rtl_bridge;

    localparam int M = 9;
    localparam int N = 2;
    localparam int B = 1;
    localparam int W = M * B;
    localparam int NRX = 24;
    localparam int NTX = 24;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [M*N-1:0] rx_rails;
    logic           rx_en;
    logic           rx_valid;
    logic [W-1:0]   rx_data;
    logic           rx_ready;
    logic           tx_valid;
    logic [W-1:0]   tx_data;
    logic           tx_ready;
    logic [M*N-1:0] tx_rails;
    logic           tx_en;
    logic           proto_err;

    int n_vec = 0;
    int n_err = 0;
    int rxq[$];

    e1ofn_rtl_bridge #(.M(M), .N(N)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .rx_rails  (rx_rails),
        .rx_en     (rx_en),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_rails  (tx_rails),
        .tx_en     (tx_en),
        .proto_err (proto_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Digit i of w selects rail (i*N + digit value).
    function automatic logic [M*N-1:0] enc(input int w);
        logic [M*N-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            int d;
            d = (w >> (i * B)) % (1 << B);
            if (d >= N) d = N - 1;
            r[i*N + d] = 1'b1;
        end
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_rx_en(input logic v, input int lim, input string tag);
        int t = 0;
        while (rx_en !== v && t < lim) begin @(negedge CLK); t++; end
        chk(tag, rx_en, v);
    endtask

    task automatic wait_rx_valid(input int lim, input string tag);
        int t = 0;
        while (rx_valid !== 1'b1 && t < lim) begin @(negedge CLK); t++; end
        chk(tag, rx_valid, 1'b1);
    endtask

    task automatic wait_tx_ready(input int lim, input string tag);
        int t = 0;
        while (tx_ready !== 1'b1 && t < lim) begin @(negedge CLK); t++; end
        chk(tag, tx_ready, 1'b1);
    endtask

    task automatic wait_tx_neutral(input int lim, input string tag);
        int t = 0;
        while (tx_rails !== '0 && t < lim) begin @(negedge CLK); t++; end
        chk(tag, tx_rails, 0);
    endtask

    task automatic send_word(input int w);
        wait_tx_ready(6, "tx_ready_pre");
        tx_valid = 1'b1;
        tx_data  = W'(w);
        @(negedge CLK);
        tx_valid = 1'b0;
        tx_data  = W'($urandom);
        chk("tx_rails_code", tx_rails, enc(w));
        chk("tx_ready_busy", tx_ready, 1'b0);
    endtask

    task automatic rnd_rx_sender();
        for (int k = 0; k < NRX; k++) begin
            int w;
            w = $urandom_range(0, (1 << W) - 1);
            wait_rx_en(1'b1, 60, "rnd_rx_en_hi");
            rx_rails = enc(w);
            rxq.push_back(w);
            wait_rx_en(1'b0, 8, "rnd_rx_en_lo");
            cyc($urandom_range(0, 3));
            rx_rails = '0;
        end
    endtask

    task automatic rnd_rx_consumer();
        int got = 0;
        int budget = 0;
        logic r;
        while (got < NRX && budget < 5000) begin
            @(negedge CLK);
            budget++;
            r = 1'($urandom_range(0, 1));
            rx_ready = r;
            if (rx_valid && r) begin
                if (rxq.size() == 0) chk("rnd_rx_spurious", 1, 0);
                else chk("rnd_rx_data", rx_data, rxq.pop_front());
                got++;
            end
        end
        rx_ready = 1'b1;
        chk("rnd_rx_count", got, NRX);
    endtask

    task automatic rnd_tx();
        for (int k = 0; k < NTX; k++) begin
            int w;
            w = $urandom_range(0, (1 << W) - 1);
            send_word(w);
            cyc($urandom_range(0, 3));
            chk("rnd_tx_hold", tx_rails, enc(w));
            tx_en = 1'b0;
            wait_tx_neutral(5, "rnd_tx_neutral");
            cyc($urandom_range(0, 2));
            tx_en = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; rx_rails = '0; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = '0; tx_en = 1'b0;
        cyc(3);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_rx_en", rx_en, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_tx_rails", tx_rails, 0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
        tx_en = 1'b1;
        cyc(2);
        chk("idle_tx_ready", tx_ready, 1'b1);

        // Single receive: exact 3-cycle latency
        rx_ready = 1'b1;
        rx_rails = enc('h1A5);
        cyc(2);
        chk("rx_lat_early", rx_valid, 1'b0);
        cyc(1);
        chk("rx_valid", rx_valid, 1'b1);
        chk("rx_data_1a5", rx_data, 'h1A5);
        chk("rx_en_ack", rx_en, 1'b0);
        rx_rails = '0;
        wait_rx_en(1'b1, 3, "rx_en_reopen");

        // Partial codeword is ignored until complete
        rx_rails = enc('h0AA) & {{(4*N){1'b0}}, {(5*N){1'b1}}};
        cyc(5);
        chk("partial_valid", rx_valid, 1'b0);
        chk("partial_en", rx_en, 1'b1);
        rx_rails = enc('h0AA);
        wait_rx_valid(4, "partial_done");
        chk("partial_data", rx_data, 'h0AA);
        rx_rails = '0;
        wait_rx_en(1'b1, 4, "partial_reopen");

        // Backpressure: full buffer keeps rx_en low after neutral
        rx_ready = 1'b0;
        rx_rails = enc('h001);
        wait_rx_en(1'b0, 5, "bp_ack1");
        chk("bp_data1", rx_data, 'h001);
        rx_rails = '0;
        cyc(6);
        chk("bp_en_held", rx_en, 1'b0);
        chk("bp_valid_held", rx_valid, 1'b1);
        chk("bp_data_held", rx_data, 'h001);
        rx_ready = 1'b1;
        @(negedge CLK);
        chk("bp_drained", rx_valid, 1'b0);
        chk("bp_en_reopen", rx_en, 1'b1);
        rx_ready = 1'b0;
        rx_rails = enc('h1FF);
        wait_rx_valid(4, "bp_valid2");
        chk("bp_data2", rx_data, 'h1FF);
        rx_ready = 1'b1;
        rx_rails = '0;
        wait_rx_en(1'b1, 5, "bp_reopen2");

        // Send 0F3 with full four-phase handshake
        send_word('h0F3);
        cyc(4);
        chk("tx_hold", tx_rails, enc('h0F3));
        tx_en = 1'b0;
        wait_tx_neutral(3, "tx_neutral");
        chk("tx_ready_neutral", tx_ready, 1'b0);
        tx_en = 1'b1;
        wait_tx_ready(3, "tx_ready_back");

        // Randomized concurrent traffic on both halves
        fork
            rnd_rx_sender();
            rnd_rx_consumer();
            rnd_tx();
        join
        chk("rnd_proto_err", proto_err, 1'b0);

        // Multi-hot digit 4: sticky error, no capture
        rx_ready = 1'b1;
        rx_rails = enc('h000) | (18'b1 << (4*N + 1));
        cyc(4);
        chk("perr_set", proto_err, 1'b1);
        chk("perr_no_valid", rx_valid, 1'b0);
        chk("perr_en", rx_en, 1'b1);
        rx_rails = '0;
        cyc(4);
        chk("perr_sticky", proto_err, 1'b1);
        rx_ready = 1'b0;
        rx_rails = enc('h055);
        wait_rx_valid(4, "perr_after_valid");
        chk("perr_after_data", rx_data, 'h055);
        chk("perr_still", proto_err, 1'b1);
        rx_ready = 1'b1;
        rx_rails = '0;
        wait_rx_en(1'b1, 5, "perr_reopen");

        // Reset in R_ACK and S_WAIT_ACK acts without a clock edge
        rx_ready = 1'b0;
        rx_rails = enc('h133);
        wait_rx_en(1'b0, 5, "mid_rx_ack");
        send_word('h0AA);
        RESET = 1'b1;
        #1;
        chk("mid_tx_rails", tx_rails, 0);
        chk("mid_rx_en", rx_en, 1'b1);
        chk("mid_rx_valid", rx_valid, 1'b0);
        chk("mid_tx_ready", tx_ready, 1'b0);
        chk("mid_proto_err", proto_err, 1'b0);
        rx_rails = '0;
        cyc(2);
        RESET = 1'b0;
        cyc(3);
        chk("post_rx_en", rx_en, 1'b1);
        chk("post_tx_ready", tx_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
